// File: rtl/qnet_cmd_sched_pkg.sv
// Shared types for the QICK network timed-command scheduler: request kinds,
// control opcodes, the queued command record and the head FSM states.
package qnet_cmd_sched_pkg;

   // Request kind presented with each command.
   typedef enum logic [1:0] {
      X_NOP  = 2'd0,
      X_NOW  = 2'd1,
      X_TIME = 2'd2,
      X_EXT  = 2'd3
   } TYPE_CTRL_REQ;

   // Default widths of the network time/core control path.
   localparam int QNET_TW  = 48;
   localparam int QNET_OPW = 4;

   // Control opcodes carried through the scheduler untouched.
   typedef enum logic [QNET_OPW-1:0] {
      OP_NOP      = 4'd0,
      OP_START    = 4'd1,
      OP_STOP     = 4'd2,
      OP_SET_TIME = 4'd3,
      OP_UPD_OFF  = 4'd4,
      OP_SYNC_REQ = 4'd5
   } TYPE_CTRL_OP;

   // Queued command at the default widths; the scheduler re-declares the
   // same layout at its own TW/OPW and hands it to the queue as a type.
   typedef struct packed {
      TYPE_CTRL_REQ          req;
      logic [QNET_OPW-1:0]   op;
      logic [QNET_TW-1:0]    dt;
   } TYPE_SCHED_CMD;

   // Head-of-queue release FSM.
   typedef enum logic [1:0] {
      H_IDLE      = 2'd0,
      H_WAIT_TIME = 2'd1,
      H_WAIT_SYNC = 2'd2,
      H_EXEC      = 2'd3
   } TYPE_HEAD_ST;

endpackage

// File: rtl/qnet_cmd_sched_if.sv
// Command request / release bundle between a command source and the scheduler.
interface qnet_cmd_sched_if
   import qnet_cmd_sched_pkg::*;
#(
   parameter int TW    = 48,
   parameter int OPW   = 4,
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   TYPE_CTRL_REQ     cmd_req_i;
   logic [OPW-1:0]   cmd_op_i;
   logic [TW-1:0]    cmd_dt_i;
   logic             cmd_rdy_o;
   logic             exec_vld_o;
   logic [OPW-1:0]   exec_op_o;
   logic             err_late_o;
   logic             err_to_o;
   logic [CW-1:0]    q_cnt_o;

   modport master (
      output cmd_req_i, cmd_op_i, cmd_dt_i,
      input  cmd_rdy_o, exec_vld_o, exec_op_o, err_late_o, err_to_o, q_cnt_o
   );

   modport slave (
      input  cmd_req_i, cmd_op_i, cmd_dt_i,
      output cmd_rdy_o, exec_vld_o, exec_op_o, err_late_o, err_to_o, q_cnt_o
   );

endinterface

// File: rtl/qnet_sched_fifo.sv
// In-order command queue: DEPTH entries of type T, synchronous write,
// combinational head read, registered occupancy, synchronous clear.
module qnet_sched_fifo
   import qnet_cmd_sched_pkg::*;
#(
   parameter type T     = TYPE_SCHED_CMD,
   parameter int  DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          t_clk_i,
   input  logic          t_rst_i,
   input  logic          clr,
   input  logic          push,
   input  T              wr_data,
   input  logic          pop,
   output T              rd_data,
   output logic [CW-1:0] cnt
);

   T              mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop && (cnt != '0) && !clr;
   assign do_push = push && !clr && ((cnt != CW'(DEPTH)) || do_pop);
   assign rd_data = mem[rd_ptr];

   // Storage array; payload carries no reset.
   always_ff @(posedge t_clk_i) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap modulo DEPTH; count is unchanged on simultaneous push and pop.
   always_ff @(posedge t_clk_i or posedge t_rst_i) begin
      if (t_rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/qnet_cmd_sched.sv
// Timed-command scheduler: captures NOW/TIME/EXT requests, rejects TIME
// commands that cannot make it once round-trip delay is added, queues the
// rest in order and releases the head as a one-cycle exec pulse.
module qnet_cmd_sched
   import qnet_cmd_sched_pkg::*;
#(
   parameter int TW      = 48,
   parameter int OPW     = 4,
   parameter int DEPTH   = 8,
   parameter int SYNC_TO = 1024
) (
   input  logic           t_clk_i,
   input  logic           t_rst_i,
   input  logic           flush_i,
   input  logic           net_sync_i,
   input  logic [31:0]    rtd_i,
   input  logic [TW-1:0]  t_time_abs_i,
   qnet_cmd_sched_if.slave cmd_if
);

   localparam int CW  = $clog2(DEPTH) + 1;
   localparam int TOW = (SYNC_TO > 1) ? $clog2(SYNC_TO) : 1;

   typedef struct packed {
      TYPE_CTRL_REQ    req;
      logic [OPW-1:0]  op;
      logic [TW-1:0]   dt;
   } sched_cmd_t;

   // Late when dt - now - rtd is negative in TW-bit modular time; zero slack is on time.
   function automatic logic late_chk(input logic [TW-1:0] dt,
                                     input logic [TW-1:0] now,
                                     input logic [TW-1:0] rtd);
      logic signed [TW-1:0] slack;
      slack = dt - now - rtd;
      return slack[TW-1];
   endfunction

   // Due once the remaining time has reached zero or gone negative (wrap-safe).
   function automatic logic due_chk(input logic [TW-1:0] dt,
                                    input logic [TW-1:0] now);
      logic signed [TW-1:0] left;
      left = dt - now;
      return left[TW-1] || (left == '0);
   endfunction

   logic [TW-1:0]  rtd;
   logic [CW:0]    occ;
   logic           rdy;
   logic           accept;
   logic [CW-1:0]  q_cnt;

   logic           vld_p0;
   sched_cmd_t     cmd_p0;
   sched_cmd_t     cmd_in;
   logic           late_s1;
   logic           push;
   logic           pop;
   sched_cmd_t     head;

   TYPE_HEAD_ST    state;
   TYPE_HEAD_ST    state_nx;
   logic [TOW-1:0] timer;
   logic           to_hit;
   logic           exec_nx;
   logic           err_to_nx;

   logic           exec_vld_p1;
   logic [OPW-1:0] exec_op_p1;
   logic           late_p1;
   logic           err_to_p1;

   assign rtd    = TW'(rtd_i);
   assign occ    = {1'b0, q_cnt} + {{CW{1'b0}}, vld_p0};
   assign rdy    = !flush_i && (occ < (CW+1)'(DEPTH));
   assign accept = rdy && (cmd_if.cmd_req_i != X_NOP);
   assign cmd_in = '{req: cmd_if.cmd_req_i, op: cmd_if.cmd_op_i, dt: cmd_if.cmd_dt_i};

   // ---- S0: request capture ----
   // Capture valid for an accepted request; cleared by flush.
   always_ff @(posedge t_clk_i or posedge t_rst_i) begin
      if (t_rst_i)      vld_p0 <= 1'b0;
      else if (flush_i) vld_p0 <= 1'b0;
      else              vld_p0 <= accept;
   end

   // Capture the request payload on accept.
   always_ff @(posedge t_clk_i) begin
      if (accept) cmd_p0 <= cmd_in;
   end

   // ---- S1: late check and enqueue ----
   assign late_s1 = vld_p0 && (cmd_p0.req == X_TIME) && late_chk(cmd_p0.dt, t_time_abs_i, rtd);
   assign push    = vld_p0 && !late_s1 && !flush_i;

   qnet_sched_fifo #(
      .T     (sched_cmd_t),
      .DEPTH (DEPTH)
   ) u_fifo (
      .t_clk_i (t_clk_i),
      .t_rst_i (t_rst_i),
      .clr     (flush_i),
      .push    (push),
      .wr_data (cmd_p0),
      .pop     (pop),
      .rd_data (head),
      .cnt     (q_cnt)
   );

   // ---- Head release FSM ----
   assign to_hit = (SYNC_TO != 0) && (timer == TOW'(SYNC_TO - 1));

   // Head FSM state register.
   always_ff @(posedge t_clk_i or posedge t_rst_i) begin
      if (t_rst_i) state <= H_IDLE;
      else         state <= state_nx;
   end

   // EXT wait timer: zero on the first waiting cycle, counts while waiting.
   always_ff @(posedge t_clk_i or posedge t_rst_i) begin
      if (t_rst_i)                              timer <= '0;
      else if (flush_i || state != H_WAIT_SYNC) timer <= '0;
      else                                      timer <= timer + 1'b1;
   end

   // Next state, pop and pulse requests; a sync seen while the EXT head is
   // being picked up already counts, so it goes straight to release.
   always_comb begin
      state_nx  = state;
      pop       = 1'b0;
      exec_nx   = 1'b0;
      err_to_nx = 1'b0;
      case (state)
         H_IDLE: begin
            if (q_cnt != '0) begin
               case (head.req)
                  X_NOW:   state_nx = H_EXEC;
                  X_TIME:  state_nx = H_WAIT_TIME;
                  X_EXT:   state_nx = net_sync_i ? H_EXEC : H_WAIT_SYNC;
                  default: pop = 1'b1;
               endcase
            end
         end
         H_WAIT_TIME: begin
            if (due_chk(head.dt, t_time_abs_i)) state_nx = H_EXEC;
         end
         H_WAIT_SYNC: begin
            if (net_sync_i) begin
               state_nx = H_EXEC;
            end else if (to_hit) begin
               pop       = 1'b1;
               err_to_nx = 1'b1;
               state_nx  = H_IDLE;
            end
         end
         H_EXEC: begin
            pop      = 1'b1;
            exec_nx  = 1'b1;
            state_nx = H_IDLE;
         end
         default: state_nx = H_IDLE;
      endcase
      if (flush_i) begin
         state_nx  = H_IDLE;
         pop       = 1'b0;
         exec_nx   = 1'b0;
         err_to_nx = 1'b0;
      end
   end

   // ---- Output pulses ----
   // Exec/error pulses; the released opcode holds between releases.
   always_ff @(posedge t_clk_i or posedge t_rst_i) begin
      if (t_rst_i) begin
         exec_vld_p1 <= 1'b0;
         exec_op_p1  <= '0;
         late_p1     <= 1'b0;
         err_to_p1   <= 1'b0;
      end else begin
         exec_vld_p1 <= exec_nx;
         late_p1     <= late_s1 && !flush_i;
         err_to_p1   <= err_to_nx;
         if (exec_nx) exec_op_p1 <= head.op;
      end
   end

   assign cmd_if.cmd_rdy_o  = rdy;
   assign cmd_if.exec_vld_o = exec_vld_p1;
   assign cmd_if.exec_op_o  = exec_op_p1;
   assign cmd_if.err_late_o = late_p1;
   assign cmd_if.err_to_o   = err_to_p1;
   assign cmd_if.q_cnt_o    = q_cnt;

endmodule
